hdmi_period_sequencer: RTL
==========================

// Module: hdmi_period_sequencer
// PURPOSE
//  Upstream of the per-channel TMDS encoders. Each cycle it classifies the pixel position (cx, cy) into an
//  HDMI period, and registers the encoder mode, the CTL preamble bits and hsync/vsync. It also schedules
//  data islands in horizontal blanking and paces the packet assembler with a per-packet handshake.
// PARAMETERS
//  BIT_WIDTH   10   width of cx
//  BIT_HEIGHT  10   width of cy
//  H_ACTIVE 640, H_FRONT 16, H_SYNC 96, H_TOTAL 800   horizontal timing (pixels)
//  V_ACTIVE 480, V_FRONT 10, V_SYNC 2,  V_TOTAL 525   vertical timing (lines)
//  SYNC_POL    0    active level of hsync/vsync
//  ISLAND_GAP  4    control cycles between end of active video and island preamble
//  MIN_CTRL    4    minimum control cycles between island trailing guard and video preamble
// PORTS
//  clk           in   1          pixel clock
//  reset         in   1          synchronous, active-high
//  cx            in   BIT_WIDTH  current column, 0..H_TOTAL-1
//  cy            in   BIT_HEIGHT current line, 0..V_TOTAL-1
//  packet_valid  in   1          assembler has a packet ready
//  mode          out  3          0 CTRL, 1 VIDEO, 2 VIDEO_GB, 3 ISLAND, 4 ISLAND_GB
//  ctl           out  4          {CTL3..CTL0}: 0001 video preamble, 0101 island preamble, else 0000
//  hsync, vsync  out  1          sync levels (SYNC_POL applied)
//  packet_start  out  1          pulse on first data cycle of each packet; assembler commits packet here
//  packet_slot   out  5          0..31 position within current packet (0 outside ISLAND)
//  island_first  out  1          high only on first data cycle of an island
// BEHAVIOUR
//  - All outputs registered; outputs in cycle n+1 describe (cx, cy) sampled at edge n. Latency 1.
//  - Reset: mode=CTRL, ctl=0, hsync=vsync=~SYNC_POL, packet_start=island_first=0, packet_slot=0, state=CTRL,
//    pkt_count=0. Reset asserted mid-island forces CTRL the next cycle; no partial trailing guard is sent.
//  - Derived: next_active = ((cy+1)==V_TOTAL ? 0 : cy+1) < V_ACTIVE.
//    ISTART = H_ACTIVE+ISLAND_GAP. VPRE_START = H_TOTAL-10.
//    MAX_PKTS = min(18, (VPRE_START-MIN_CTRL-(ISTART+12))/32). Default gives 4.
//  - Video: VIDEO when cx<H_ACTIVE && cy<V_ACTIVE. VPRE when cx in [H_TOTAL-10, H_TOTAL-3] && next_active
//    (mode CTRL, ctl 0001). VIDEO_GB when cx in [H_TOTAL-2, H_TOTAL-1] && next_active.
//  - hsync active when cx in [H_ACTIVE+H_FRONT, +H_SYNC). vsync active when cy in [V_ACTIVE+V_FRONT, +V_SYNC).
//  - FSM: CTRL -> IPRE -> ILGB -> IDATA -> ITGB -> CTRL. Video periods are decoded from cx and override only CTRL.
//    CTRL->IPRE when cx==ISTART && packet_valid && MAX_PKTS>0. This is allowed on any line, including vblank.
//    IPRE lasts 8 cycles, mode CTRL, ctl 0101. ILGB lasts 2 cycles, mode ISLAND_GB.
//    IDATA: mode ISLAND. packet_slot counts 0..31. packet_start=1 when slot 0. island_first on first slot 0 only.
//    At slot 31: pkt_count+1 < MAX_PKTS && packet_valid -> slot 0 of next packet; else -> ITGB.
//    ITGB lasts 2 cycles, mode ISLAND_GB, then CTRL and pkt_count cleared.
//  - packet_valid is sampled only at ISTART and at slot 31. A drop mid-packet does not truncate the packet.
//  - cx/cy out of range: treat as CTRL. Any island in progress finishes its ITGB normally.
//  - Default 640x480 schedule: IPRE 644..651, ILGB 652..653, data 654..781 (4 pkts), ITGB 782..783,
//    ctrl 784..789, VPRE 790..797, VGB 798..799.
//  - Counters: 3-bit preamble/guard counter, 5-bit slot, 5-bit pkt_count; slot wraps 31->0 only inside IDATA.
// STRUCTURE
//  - hdmi_pkg: mode enum (CTRL/VIDEO/VIDEO_GB/ISLAND/ISLAND_GB), CTL_VIDEO_PRE=4'b0001, CTL_ISLAND_PRE=4'b0101,
//    PREAMBLE_LEN=8, GUARD_LEN=2, PACKET_LEN=32, MAX_ISLAND_PKTS=18.
//  - One sub-module: hdmi_timing_window (combinational decode of cx/cy into active, next_active, hsync, vsync, vpre, vgb).
//    The island FSM stays in this module.
// TESTING (default 640x480 parameters)
//  - Reset held 3 cycles, then sweep cx=0..799, cy=0 -> mode VIDEO for cx 0..639; hsync active cx 656..751; ctl 0 there.
//  - cy=479, packet_valid=0 -> no VPRE/VGB at cx 790..799. cy=524 -> VPRE ctl=0001 at 790..797, VIDEO_GB at 798..799.
//  - packet_valid held 1, cy=5 -> island exactly as in default schedule. 4 packet_start pulses at 654/686/718/750.
//    island_first only at 654.
//  - packet_valid=1 at cx 644, dropped at cx 660 -> exactly 1 packet (slot 0..31 over 654..685), then ITGB 686..687.
//  - reset pulsed at cx 700 during IDATA -> next cycle mode CTRL, packet_slot 0. No island until next line's cx 644.
//  - packet_valid=1 on cy=490 (vsync line) -> island scheduled, vsync active throughout, no VPRE at line end.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI period sequencer.
package hdmi_pkg;

    typedef enum logic [2:0] {
        MODE_CTRL      = 3'd0,
        MODE_VIDEO     = 3'd1,
        MODE_VIDEO_GB  = 3'd2,
        MODE_ISLAND    = 3'd3,
        MODE_ISLAND_GB = 3'd4
    } mode_t;

    typedef enum logic [2:0] {
        ST_CTRL  = 3'd0,
        ST_IPRE  = 3'd1,
        ST_ILGB  = 3'd2,
        ST_IDATA = 3'd3,
        ST_ITGB  = 3'd4
    } state_t;

    localparam logic [3:0] CTL_NONE       = 4'b0000;
    localparam logic [3:0] CTL_VIDEO_PRE  = 4'b0001;
    localparam logic [3:0] CTL_ISLAND_PRE = 4'b0101;

    localparam int PREAMBLE_LEN    = 8;
    localparam int GUARD_LEN       = 2;
    localparam int PACKET_LEN      = 32;
    localparam int MAX_ISLAND_PKTS = 18;

    // Packets that fit between island start and the video preamble.
    function automatic int calc_max_pkts(
        input int istart,
        input int vpre_start,
        input int min_ctrl
    );
        int room;
        int n;
        room = vpre_start - min_ctrl
             - (istart + PREAMBLE_LEN + 2 * GUARD_LEN);
        if (room < 0) return 0;
        n = room / PACKET_LEN;
        return (n > MAX_ISLAND_PKTS) ? MAX_ISLAND_PKTS : n;
    endfunction

endpackage

// File: rtl/hdmi_timing_window.sv
// Combinational decode of pixel position into raster windows.
module hdmi_timing_window
    import hdmi_pkg::*;
#(
    parameter int BIT_WIDTH  = 10,
    parameter int BIT_HEIGHT = 10,
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_TOTAL    = 525
) (
    input  logic [BIT_WIDTH-1:0]  cx,
    input  logic [BIT_HEIGHT-1:0] cy,
    output logic                  in_range,
    output logic                  active,
    output logic                  next_active,
    output logic                  hsync_on,
    output logic                  vsync_on,
    output logic                  vpre,
    output logic                  vgb
);

    localparam int XW = BIT_WIDTH + 1;
    localparam int YW = BIT_HEIGHT + 1;

    localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_TOT  = XW'(H_TOTAL);
    localparam logic [XW-1:0] X_HS0  = XW'(H_ACTIVE + H_FRONT);
    localparam logic [XW-1:0] X_HS1  = XW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [XW-1:0] X_VP0  = XW'(H_TOTAL - 10);
    localparam logic [XW-1:0] X_VP1  = XW'(H_TOTAL - 3);
    localparam logic [XW-1:0] X_GB0  = XW'(H_TOTAL - 2);
    localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_TOT  = YW'(V_TOTAL);
    localparam logic [YW-1:0] Y_VS0  = YW'(V_ACTIVE + V_FRONT);
    localparam logic [YW-1:0] Y_VS1  = YW'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [YW-1:0] y_inc;
    logic [YW-1:0] y_next;

    always_comb begin
        x      = {1'b0, cx};
        y      = {1'b0, cy};
        y_inc  = y + YW'(1);
        y_next = (y_inc == Y_TOT) ? '0 : y_inc;
    end

    assign in_range    = (x < X_TOT) && (y < Y_TOT);
    assign next_active = in_range && (y_next < Y_ACT);
    assign active      = in_range && (x < X_ACT) && (y < Y_ACT);
    assign hsync_on    = (x >= X_HS0) && (x < X_HS1);
    assign vsync_on    = (y >= Y_VS0) && (y < Y_VS1);
    assign vpre        = in_range && (x >= X_VP0) && (x <= X_VP1);
    assign vgb         = in_range && (x >= X_GB0);

endmodule

// File: rtl/hdmi_period_sequencer.sv
// Classifies each pixel into an HDMI period and schedules data islands
// in horizontal blanking, pacing the packet assembler.
module hdmi_period_sequencer
    import hdmi_pkg::*;
#(
    parameter int   BIT_WIDTH  = 10,
    parameter int   BIT_HEIGHT = 10,
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_TOTAL    = 800,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_TOTAL    = 525,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   ISLAND_GAP = 4,
    parameter int   MIN_CTRL   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIT_WIDTH-1:0]  cx,
    input  logic [BIT_HEIGHT-1:0] cy,
    input  logic                  packet_valid,
    output logic [2:0]            mode,
    output logic [3:0]            ctl,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  packet_start,
    output logic [4:0]            packet_slot,
    output logic                  island_first
);

    localparam int ISTART     = H_ACTIVE + ISLAND_GAP;
    localparam int VPRE_START = H_TOTAL - 10;
    localparam int MAX_PKTS   =
        calc_max_pkts(ISTART, VPRE_START, MIN_CTRL);

    localparam logic [BIT_WIDTH:0] X_ISTART =
        (BIT_WIDTH + 1)'(ISTART);
    localparam logic [5:0] MAX_P      = 6'(MAX_PKTS);
    localparam logic       ISLANDS_ON = (MAX_PKTS > 0);
    localparam logic [2:0] PRE_LAST   = 3'(PREAMBLE_LEN - 1);
    localparam logic [2:0] GB_LAST    = 3'(GUARD_LEN - 1);
    localparam logic [4:0] SLOT_LAST  = 5'(PACKET_LEN - 1);

    logic in_range;
    logic active;
    logic next_active;
    logic hsync_on;
    logic vsync_on;
    logic vpre_win;
    logic vgb_win;
    logic island_go;
    logic more_pkts;

    state_t     state;
    logic [2:0] cnt;
    logic [4:0] slot;
    logic [4:0] pkt_count;

    hdmi_timing_window #(
        .BIT_WIDTH  (BIT_WIDTH),
        .BIT_HEIGHT (BIT_HEIGHT),
        .H_ACTIVE   (H_ACTIVE),
        .H_FRONT    (H_FRONT),
        .H_SYNC     (H_SYNC),
        .H_TOTAL    (H_TOTAL),
        .V_ACTIVE   (V_ACTIVE),
        .V_FRONT    (V_FRONT),
        .V_SYNC     (V_SYNC),
        .V_TOTAL    (V_TOTAL)
    ) u_window (
        .cx          (cx),
        .cy          (cy),
        .in_range    (in_range),
        .active      (active),
        .next_active (next_active),
        .hsync_on    (hsync_on),
        .vsync_on    (vsync_on),
        .vpre        (vpre_win),
        .vgb         (vgb_win)
    );

    assign island_go = ISLANDS_ON && in_range && packet_valid
                    && ({1'b0, cx} == X_ISTART);
    assign more_pkts = packet_valid
                    && (({1'b0, pkt_count} + 6'd1) < MAX_P);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_CTRL;
            cnt          <= '0;
            slot         <= '0;
            pkt_count    <= '0;
            mode         <= MODE_CTRL;
            ctl          <= CTL_NONE;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            packet_start <= 1'b0;
            packet_slot  <= '0;
            island_first <= 1'b0;
        end else begin
            hsync        <= hsync_on ? SYNC_POL : ~SYNC_POL;
            vsync        <= vsync_on ? SYNC_POL : ~SYNC_POL;
            mode         <= MODE_CTRL;
            ctl          <= CTL_NONE;
            packet_start <= 1'b0;
            packet_slot  <= '0;
            island_first <= 1'b0;
            unique case (state)
                ST_CTRL: begin
                    // The start cycle itself is the first preamble cycle.
                    if (island_go) begin
                        ctl   <= CTL_ISLAND_PRE;
                        state <= ST_IPRE;
                        cnt   <= 3'd1;
                    end else if (active) begin
                        mode <= MODE_VIDEO;
                    end else if (vpre_win && next_active) begin
                        ctl <= CTL_VIDEO_PRE;
                    end else if (vgb_win && next_active) begin
                        mode <= MODE_VIDEO_GB;
                    end
                end
                ST_IPRE: begin
                    ctl <= CTL_ISLAND_PRE;
                    if (cnt == PRE_LAST) begin
                        state <= ST_ILGB;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_ILGB: begin
                    mode <= MODE_ISLAND_GB;
                    if (cnt == GB_LAST) begin
                        state     <= ST_IDATA;
                        cnt       <= '0;
                        slot      <= '0;
                        pkt_count <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_IDATA: begin
                    mode         <= MODE_ISLAND;
                    packet_slot  <= slot;
                    packet_start <= (slot == 5'd0);
                    island_first <= (slot == 5'd0)
                                 && (pkt_count == 5'd0);
                    if (slot != SLOT_LAST) begin
                        slot <= slot + 5'd1;
                    end else if (more_pkts) begin
                        slot      <= '0;
                        pkt_count <= pkt_count + 5'd1;
                    end else begin
                        slot  <= '0;
                        state <= ST_ITGB;
                        cnt   <= '0;
                    end
                end
                ST_ITGB: begin
                    mode <= MODE_ISLAND_GB;
                    if (cnt == GB_LAST) begin
                        state     <= ST_CTRL;
                        cnt       <= '0;
                        pkt_count <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= ST_CTRL;
                end
            endcase
        end
    end

endmodule
